// File: rtl/decode_pipe_pkg.sv
// decode_pipe_pkg: LC-3b types, control word and control ROM shared by the decode stage
package decode_pipe_pkg;

    typedef logic [2:0] lc3b_nzp;

    typedef enum logic [3:0] {
        OP_BR, OP_ADD, OP_LDB, OP_STB, OP_JSR, OP_AND, OP_LDR, OP_STR,
        OP_RTI, OP_XOR, OP_RSV_A, OP_RSV_B, OP_JMP, OP_SHF, OP_LEA, OP_TRAP
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic       load_regfile;
        logic       load_cc;
        logic       use_sr1;
        logic       use_sr2;
        logic       use_cc;
        logic       sr2_sel;
        logic       dest_sel;
    } lc3b_control_word;

    // JSR and JSRR share an opcode; both are treated as reading the base register.
    function automatic lc3b_control_word control_rom(lc3b_opcode op, logic imm);
        lc3b_control_word cw;
        cw              = '0;
        cw.opcode       = op;
        cw.load_regfile = op inside {OP_ADD, OP_AND, OP_XOR, OP_SHF, OP_LDB, OP_LDR, OP_LEA, OP_JSR, OP_TRAP};
        cw.load_cc      = op inside {OP_ADD, OP_AND, OP_XOR, OP_SHF, OP_LDB, OP_LDR};
        cw.use_sr1      = op inside {OP_ADD, OP_AND, OP_XOR, OP_SHF, OP_LDB, OP_LDR, OP_STB, OP_STR, OP_JMP, OP_JSR};
        cw.use_sr2      = (op inside {OP_ADD, OP_AND, OP_XOR} && !imm) || op inside {OP_STB, OP_STR};
        cw.use_cc       = op == OP_BR;
        cw.sr2_sel      = op inside {OP_STB, OP_STR};
        cw.dest_sel     = op inside {OP_JSR, OP_TRAP};
        return cw;
    endfunction

endpackage

// File: rtl/decode_pipe_if.sv
// decode_pipe_if: fetch, writeback and execute-side signals of the decode stage
interface decode_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    import decode_pipe_pkg::*;

    localparam int RW = $clog2(NREGS);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_npc;
    logic [15:0]      in_ir;
    logic             wb_valid;
    logic [RW-1:0]    wb_dest;
    logic [WIDTH-1:0] wb_data;
    logic             wb_cc_valid;
    lc3b_nzp          wb_cc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_npc;
    logic [15:0]      out_ir;
    lc3b_control_word out_cw;
    logic [WIDTH-1:0] out_sr1;
    logic [WIDTH-1:0] out_sr2;
    lc3b_nzp          out_cc;
    logic [RW-1:0]    out_dr;
    logic             stall;

    modport master (
        output in_valid, in_npc, in_ir, wb_valid, wb_dest, wb_data, wb_cc_valid, wb_cc, flush, out_ready,
        input  in_ready, out_valid, out_npc, out_ir, out_cw, out_sr1, out_sr2, out_cc, out_dr, stall
    );

    modport slave (
        input  in_valid, in_npc, in_ir, wb_valid, wb_dest, wb_data, wb_cc_valid, wb_cc, flush, out_ready,
        output in_ready, out_valid, out_npc, out_ir, out_cw, out_sr1, out_sr2, out_cc, out_dr, stall
    );

endinterface

// File: rtl/decode_pipe_scoreboard.sv
// decode_pipe_scoreboard: per-entry counters of writes issued but not yet written back
module decode_pipe_scoreboard #(
    parameter int  NREGS  = 8,
    parameter int  PEND_W = 2,
    localparam int IW     = NREGS > 1 ? $clog2(NREGS) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         inc,
    input  logic [IW-1:0]                inc_idx,
    input  logic                         dec,
    input  logic [IW-1:0]                dec_idx,
    output logic [NREGS-1:0][PEND_W-1:0] eff,
    output logic [NREGS-1:0]             full
);

    logic [NREGS-1:0][PEND_W-1:0] pend_q, pend_d;

    // Count as seen after this cycle's writeback, so a retiring write releases its reader at once
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            eff[r]  = dec && dec_idx == IW'(r) && pend_q[r] != '0 ? pend_q[r] - 1'b1 : pend_q[r];
            full[r] = &pend_q[r];
        end
    end

    // Issue and retire on the same entry cancel out; flush drops every count
    always_comb begin
        pend_d = '0;
        if (!clear)
            for (int r = 0; r < NREGS; r++)
                pend_d[r] = inc && inc_idx == IW'(r) ? (dec && dec_idx == IW'(r) ? pend_q[r] : pend_q[r] + 1'b1) : eff[r];
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (!reset_n) pend_q <= '0;
        else          pend_q <= pend_d;
    end

endmodule

// File: rtl/decode_pipe.sv
// decode_pipe: LC-3b decode stage with register file, hazard scoreboard and ID/EX register
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int NREGS  = 8,
    parameter int PEND_W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    decode_pipe_if.slave bus
);

    localparam int RW = $clog2(NREGS);

    typedef struct packed {
        logic [WIDTH-1:0] npc;
        logic [15:0]      ir;
        lc3b_control_word cw;
        logic [WIDTH-1:0] sr1;
        logic [WIDTH-1:0] sr2;
        lc3b_nzp          cc;
        logic [RW-1:0]    dr;
    } idex_t;

    lc3b_control_word             cw;
    logic [RW-1:0]                sr1, sr2, dr;
    logic [WIDTH-1:0]             sr1_val, sr2_val;
    lc3b_nzp                      cc_val;
    logic                         hazard, accept;
    logic [NREGS-1:0][PEND_W-1:0] reg_eff;
    logic [NREGS-1:0]             reg_full;
    logic [0:0][PEND_W-1:0]       cc_eff;
    logic [0:0]                   cc_full;

    logic [NREGS-1:0][WIDTH-1:0]  regs_q, regs_d;
    lc3b_nzp                      cc_q, cc_d;
    logic                         out_valid_q, out_valid_d;
    idex_t                        idex_q, idex_d;

    // Decode, operand read with writeback bypass, hazard detection and input handshake
    always_comb begin
        cw           = control_rom(lc3b_opcode'(bus.in_ir[15:12]), bus.in_ir[5]);
        sr1          = RW'(bus.in_ir[8:6]);
        sr2          = RW'(cw.sr2_sel ? bus.in_ir[11:9] : bus.in_ir[2:0]);
        dr           = cw.dest_sel ? RW'(NREGS - 1) : RW'(bus.in_ir[11:9]);
        sr1_val      = bus.wb_valid && bus.wb_dest == sr1 ? bus.wb_data : regs_q[sr1];
        sr2_val      = bus.wb_valid && bus.wb_dest == sr2 ? bus.wb_data : regs_q[sr2];
        cc_val       = bus.wb_cc_valid ? bus.wb_cc : cc_q;
        hazard       = (cw.use_sr1 && reg_eff[sr1] != '0) || (cw.use_sr2 && reg_eff[sr2] != '0)
                    || (cw.use_cc && cc_eff[0] != '0) || (cw.load_regfile && reg_full[dr])
                    || (cw.load_cc && cc_full[0]);
        bus.in_ready = (!out_valid_q || bus.out_ready) && !hazard && !bus.flush;
        bus.stall    = bus.in_valid && hazard;
        accept       = bus.in_valid && bus.in_ready;
    end

    // Architectural writes and ID/EX register next state; flush only squashes the output
    always_comb begin
        regs_d = regs_q;
        if (bus.wb_valid) regs_d[bus.wb_dest] = bus.wb_data;
        cc_d        = bus.wb_cc_valid ? bus.wb_cc : cc_q;
        out_valid_d = !bus.flush && (accept || (out_valid_q && !bus.out_ready));
        idex_d      = accept ? '{npc: bus.in_npc, ir: bus.in_ir, cw: cw, sr1: sr1_val, sr2: sr2_val, cc: cc_val, dr: dr}
                             : idex_q;
    end

    // State registers; reset wins over flush and writeback
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs_q      <= '0;
            cc_q        <= 3'b010;
            out_valid_q <= 1'b0;
            idex_q      <= '0;
        end else begin
            regs_q      <= regs_d;
            cc_q        <= cc_d;
            out_valid_q <= out_valid_d;
            idex_q      <= idex_d;
        end
    end

    decode_pipe_scoreboard #(.NREGS(NREGS), .PEND_W(PEND_W)) u_reg_sb (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bus.flush),
        .inc     (accept && cw.load_regfile),
        .inc_idx (dr),
        .dec     (bus.wb_valid),
        .dec_idx (bus.wb_dest),
        .eff     (reg_eff),
        .full    (reg_full)
    );

    decode_pipe_scoreboard #(.NREGS(1), .PEND_W(PEND_W)) u_cc_sb (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (bus.flush),
        .inc     (accept && cw.load_cc),
        .inc_idx (1'b0),
        .dec     (bus.wb_cc_valid),
        .dec_idx (1'b0),
        .eff     (cc_eff),
        .full    (cc_full)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_npc   = idex_q.npc;
    assign bus.out_ir    = idex_q.ir;
    assign bus.out_cw    = idex_q.cw;
    assign bus.out_sr1   = idex_q.sr1;
    assign bus.out_sr2   = idex_q.sr2;
    assign bus.out_cc    = idex_q.cc;
    assign bus.out_dr    = idex_q.dr;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed scenarios for the decode stage with hand-computed expectations
module tb_decode_pipe;
    import decode_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int errors = 0;
    int checks = 0;

    decode_pipe_if #(.WIDTH(16), .NREGS(8)) bus ();
    decode_pipe #(.WIDTH(16), .NREGS(8), .PEND_W(2)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_npc = '0; bus.in_ir = '0;
        bus.wb_valid = 0; bus.wb_dest = '0; bus.wb_data = '0;
        bus.wb_cc_valid = 0; bus.wb_cc = '0; bus.flush = 0; bus.out_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0; bus.flush = 1; bus.in_valid = 1; bus.in_ir = 16'h1283;
        bus.wb_valid = 1; bus.wb_dest = 2; bus.wb_data = 16'hFFFF; bus.wb_cc_valid = 1; bus.wb_cc = 3'b100;
        tick(); tick();
        reset_n = 1; idle(); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.out_ir !== 16'h0) begin errors++; $display("FAIL reset_ir got=%h want=0000", bus.out_ir); end
        checks++; if (bus.out_npc !== 16'h0) begin errors++; $display("FAIL reset_npc got=%h want=0000", bus.out_npc); end
        checks++; if (bus.out_cc !== 3'b000) begin errors++; $display("FAIL reset_out_cc got=%b want=000", bus.out_cc); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%0b want=1", bus.in_ready); end
        bus.in_valid = 1; bus.in_ir = 16'h0482; bus.in_npc = 16'h0002;
        tick(); bus.in_valid = 0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%0b want=1", bus.out_valid); end
        checks++; if (bus.out_cc !== 3'b010) begin errors++; $display("FAIL reset_cc got=%b want=010", bus.out_cc); end
        checks++; if (bus.out_sr1 !== 16'h0) begin errors++; $display("FAIL reset_r2 got=%h want=0000", bus.out_sr1); end
        checks++; if (bus.out_npc !== 16'h0002) begin errors++; $display("FAIL first_npc got=%h want=0002", bus.out_npc); end
    endtask

    task automatic test_add();
        bus.wb_valid = 1; bus.wb_dest = 2; bus.wb_data = 16'd5; tick();
        bus.wb_dest = 3; bus.wb_data = 16'd7; tick();
        bus.wb_valid = 0;
        bus.in_valid = 1; bus.in_ir = 16'h1283; bus.in_npc = 16'h3002; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_ready got=%0b want=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0b want=1", bus.out_valid); end
        checks++; if (bus.out_sr1 !== 16'd5) begin errors++; $display("FAIL add_sr1 got=%h want=0005", bus.out_sr1); end
        checks++; if (bus.out_sr2 !== 16'd7) begin errors++; $display("FAIL add_sr2 got=%h want=0007", bus.out_sr2); end
        checks++; if (bus.out_dr !== 3'd1) begin errors++; $display("FAIL add_dr got=%0d want=1", bus.out_dr); end
        checks++; if (bus.out_cw.load_regfile !== 1'b1) begin errors++; $display("FAIL add_cw got=%0b want=1", bus.out_cw.load_regfile); end
    endtask

    task automatic test_raw();
        bus.in_ir = 16'h1841; bus.in_npc = 16'h3004;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL raw_stall[%0d] got=%0b want=1", i, bus.stall); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL raw_ready[%0d] got=%0b want=0", i, bus.in_ready); end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL raw_drain got=%0b want=0", bus.out_valid); end
        bus.wb_valid = 1; bus.wb_dest = 1; bus.wb_data = 16'h00AA; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL raw_release got=%0b want=1", bus.in_ready); end
        tick(); bus.wb_valid = 0; bus.in_valid = 0;
        checks++; if (bus.out_sr1 !== 16'h00AA) begin errors++; $display("FAIL raw_sr1 got=%h want=00aa", bus.out_sr1); end
        checks++; if (bus.out_sr2 !== 16'h00AA) begin errors++; $display("FAIL raw_sr2 got=%h want=00aa", bus.out_sr2); end
        checks++; if (bus.out_dr !== 3'd4) begin errors++; $display("FAIL raw_dr got=%0d want=4", bus.out_dr); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 0; bus.in_valid = 1; bus.in_ir = 16'hEA10; bus.in_npc = 16'h3010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%0b want=0", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_ir !== 16'h1841 || bus.out_sr1 !== 16'h00AA || bus.out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_hold[%0d] got ir=%h sr1=%h v=%0b want ir=1841 sr1=00aa v=1", i, bus.out_ir, bus.out_sr1, bus.out_valid); end
        end
        bus.out_ready = 1; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%0b want=1", bus.in_ready); end
        tick();
        checks++; if (bus.out_ir !== 16'hEA10 || bus.out_dr !== 3'd5 || bus.out_npc !== 16'h3010)
            begin errors++; $display("FAIL bp_next got ir=%h dr=%0d npc=%h want ir=ea10 dr=5 npc=3010", bus.out_ir, bus.out_dr, bus.out_npc); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq [3] = '{16'hE001, 16'hEC02, 16'hEE03};
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_ir = seq[i]; #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got=%0b want=1", i, bus.in_ready); end
            tick();
            checks++; if (bus.out_ir !== seq[i] || bus.out_valid !== 1'b1)
                begin errors++; $display("FAIL b2b_out[%0d] got ir=%h v=%0b want ir=%h v=1", i, bus.out_ir, bus.out_valid, seq[i]); end
        end
        bus.in_valid = 0; tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_full();
        logic [15:0] seq [3] = '{16'hE400, 16'hE401, 16'hE402};
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1; bus.in_ir = seq[i]; #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_fill[%0d] got=%0b want=1", i, bus.in_ready); end
            tick();
        end
        bus.in_ir = 16'hE403;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall[%0d] got=%0b want=1", i, bus.stall); end
            tick();
        end
        checks++; if (bus.out_ir !== 16'hE402) begin errors++; $display("FAIL full_noissue got=%h want=e402", bus.out_ir); end
        bus.wb_valid = 1; bus.wb_dest = 2; bus.wb_data = 16'h1234; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_wbcycle got=%0b want=0", bus.in_ready); end
        tick(); bus.wb_valid = 0; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_release got=%0b want=1", bus.in_ready); end
        tick(); bus.in_valid = 0;
        checks++; if (bus.out_ir !== 16'hE403 || bus.out_valid !== 1'b1)
            begin errors++; $display("FAIL full_issue got ir=%h v=%0b want ir=e403 v=1", bus.out_ir, bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.in_valid = 1; bus.in_ir = 16'hEA20; tick();
        bus.flush = 1; bus.wb_valid = 1; bus.wb_dest = 5; bus.wb_data = 16'h5555;
        bus.wb_cc_valid = 1; bus.wb_cc = 3'b100; bus.in_ir = 16'h1361; bus.in_npc = 16'h3100; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0b want=0", bus.in_ready); end
        tick(); bus.flush = 0; bus.wb_valid = 0; bus.wb_cc_valid = 0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b want=0", bus.out_valid); end
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.stall !== 1'b0)
            begin errors++; $display("FAIL flush_clear got ready=%0b stall=%0b want ready=1 stall=0", bus.in_ready, bus.stall); end
        tick(); bus.in_valid = 0;
        checks++; if (bus.out_ir !== 16'h1361 || bus.out_valid !== 1'b1)
            begin errors++; $display("FAIL flush_issue got ir=%h v=%0b want ir=1361 v=1", bus.out_ir, bus.out_valid); end
        checks++; if (bus.out_sr1 !== 16'h5555) begin errors++; $display("FAIL flush_wb got=%h want=5555", bus.out_sr1); end
        checks++; if (bus.out_cc !== 3'b100) begin errors++; $display("FAIL flush_cc got=%b want=100", bus.out_cc); end
    endtask

    task automatic test_cc();
        bus.in_valid = 1; bus.in_ir = 16'h0401; bus.in_npc = 16'h3102;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL cc_stall[%0d] got=%0b want=1", i, bus.stall); end
            tick();
        end
        bus.wb_cc_valid = 1; bus.wb_cc = 3'b010; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL cc_release got=%0b want=1", bus.in_ready); end
        tick(); bus.wb_cc_valid = 0; bus.in_valid = 0;
        checks++; if (bus.out_cc !== 3'b010) begin errors++; $display("FAIL cc_bypass got=%b want=010", bus.out_cc); end
        checks++; if (bus.out_ir !== 16'h0401) begin errors++; $display("FAIL cc_ir got=%h want=0401", bus.out_ir); end
    endtask

    initial begin
        idle();
        test_reset();
        test_add();
        test_raw();
        test_backpressure();
        test_back_to_back();
        test_full();
        test_flush();
        test_cc();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
